// File: rtl/adder_accumulator.sv
// Packet accumulator: sums the beats of each packet through an external combinational
// Adder and presents sum, beat count and a sticky wrap flag once the last beat lands.
module adder_accumulator #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done;

  assign done     = (state_q == DONE);
  assign in_ready = ~done;
  assign add_a    = acc_q;
  assign add_b    = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACC: begin
        // in_ready is high in these states, so in_valid alone marks a transfer
        if (in_valid) begin
          acc_d = add_c;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (add_c < add_a) ovf_d = 1'b1;
          state_d = in_last ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = done;
  assign out_sum   = done ? acc_q : '0;
  assign out_count = done ? cnt_q : '0;
  assign out_ovf   = done & ovf_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: the Adder is modelled by a continuous add, and results are
// compared against a packet-level model (running integer sum, beat count, wrap flag).
module tb_adder_accumulator;
  localparam int WIDTH = 20;
  localparam int CNT_W = 8;
  localparam longint MODV = 64'd1 << WIDTH;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] add_a, add_b, add_c;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // packet model
  longint m_sum;
  int     m_cnt;
  bit     m_ovf;

  always #5 clk = ~clk;

  assign add_c = add_a + add_b;

  adder_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_c(add_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  function automatic void model_clear();
    m_sum = 0; m_cnt = 0; m_ovf = 0;
  endfunction

  // Presents one beat, checks the Adder operands and in_ready, then lets it transfer.
  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    longint total;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    n_cmp++;
    if ({in_ready, add_a, add_b} !== {1'b1, WIDTH'(m_sum), d}) begin
      n_bad++;
      $display("FAIL beat_operands: got ready=%0b a=%0h b=%0h, want ready=1 a=%0h b=%0h",
               in_ready, add_a, add_b, WIDTH'(m_sum), d);
    end
    @(posedge clk);
    total = m_sum + longint'(d);
    if (total >= MODV) m_ovf = 1;
    m_sum = total % MODV;
    if (m_cnt < CMAX) m_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_count, out_ovf, in_ready, add_a} !== {1'b0, WIDTH'(0), CNT_W'(0), 1'b0, 1'b1, WIDTH'(0)}) begin
      n_bad++;
      $display("FAIL reset_initial: got v=%0b s=%0h c=%0d o=%0b rdy=%0b a=%0h, want all zero, rdy=1",
               out_valid, out_sum, out_count, out_ovf, in_ready, add_a);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    model_clear();
    send_beat(20'd5, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_count, out_ovf, in_ready, add_a} !== {1'b0, WIDTH'(0), CNT_W'(0), 1'b0, 1'b1, WIDTH'(0)}) begin
      n_bad++;
      $display("FAIL reset_pulse: got v=%0b s=%0h c=%0d o=%0b rdy=%0b a=%0h, want all zero, rdy=1",
               out_valid, out_sum, out_count, out_ovf, in_ready, add_a);
    end
    #1 rst_n = 1'b1;
    model_clear();
    $display("test_reset: done");
  endtask

  // Waits one cycle after the last beat, checks the result, holds it for bp cycles, releases.
  task automatic finish_packet(input string name, input int bp);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_count, out_ovf, in_ready} !== {1'b1, WIDTH'(m_sum), CNT_W'(m_cnt), m_ovf, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_result: got v=%0b sum=%0h cnt=%0d ovf=%0b rdy=%0b, want v=1 sum=%0h cnt=%0d ovf=%0b rdy=0",
               name, out_valid, out_sum, out_count, out_ovf, in_ready, WIDTH'(m_sum), m_cnt, m_ovf);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = WIDTH'($urandom); in_last = 1'(($urandom));
      #1;
      n_cmp++;
      if ({out_valid, out_sum, out_count, out_ovf, in_ready} !== {1'b1, WIDTH'(m_sum), CNT_W'(m_cnt), m_ovf, 1'b0}) begin
        n_bad++;
        $display("FAIL %s_hold%0d: got v=%0b sum=%0h cnt=%0d ovf=%0b rdy=%0b, want v=1 sum=%0h cnt=%0d ovf=%0b rdy=0",
                 name, i, out_valid, out_sum, out_count, out_ovf, in_ready, WIDTH'(m_sum), m_cnt, m_ovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_count, out_ovf, in_ready, add_a} !== {1'b0, WIDTH'(0), CNT_W'(0), 1'b0, 1'b1, WIDTH'(0)}) begin
      n_bad++;
      $display("FAIL %s_release: got v=%0b s=%0h c=%0d o=%0b rdy=%0b a=%0h, want idle zeros",
               name, out_valid, out_sum, out_count, out_ovf, in_ready, add_a);
    end
    $display("%s: packet released", name);
  endtask

  task automatic test_two_beat();
    send_beat(20'd10, 1'b0);
    send_beat(20'd20, 1'b1);
    n_cmp++;
    if (m_sum != 30 || m_cnt != 2 || m_ovf != 0) begin
      n_bad++;
      $display("FAIL two_beat_model: got sum=%0d cnt=%0d ovf=%0b, want 30 2 0", m_sum, m_cnt, m_ovf);
    end
    finish_packet("two_beat", 0);
  endtask

  task automatic test_single_beat();
    send_beat(20'd87, 1'b1);
    finish_packet("single_beat", 0);
  endtask

  task automatic test_wrap();
    send_beat(20'hFFFFF, 1'b0);
    send_beat(20'd2, 1'b1);
    finish_packet("wrap", 0);
    send_beat(20'd8, 1'b0);
    send_beat(20'd5, 1'b1);
    finish_packet("after_wrap", 0);
  endtask

  task automatic test_backpressure();
    send_beat(20'd15, 1'b0);
    send_beat(20'd2, 1'b1);
    finish_packet("backpressure", 5);
  endtask

  task automatic test_mid_reset();
    send_beat(20'd32, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({add_a, out_valid} !== {WIDTH'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset_clear: got a=%0h v=%0b, want a=0 v=0", add_a, out_valid);
    end
    #1 rst_n = 1'b1;
    model_clear();
    send_beat(20'd22, 1'b0);
    send_beat(20'd17, 1'b1);
    finish_packet("mid_reset", 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_beat(20'd1, (i == 299) ? 1'b1 : 1'b0);
    finish_packet("saturation", 1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        logic [WIDTH-1:0] d;
        d = ($urandom_range(0, 2) == 0) ? WIDTH'(MODV - 1 - $urandom_range(0, 255)) : WIDTH'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          @(negedge clk); in_valid = 1'b0;
        end
        send_beat(d, (b == len - 1) ? 1'b1 : 1'b0);
      end
      finish_packet($sformatf("random%0d", p), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_two_beat();
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 20, giving the data and sum width, matched to the Adder operand width.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the beat-counter width.
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 The module SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 The module SHALL have port in_data  input  WIDTH  unsigned beat value.
REQ-008 The module SHALL have port in_last  input  1  final beat of packet.
REQ-009 The module SHALL have port add_a  output  WIDTH  drives Adder input a.
REQ-010 The module SHALL have port add_b  output  WIDTH  drives Adder input b.
REQ-011 The module SHALL have port add_c  input  WIDTH  Adder output c (combinational sum).
REQ-012 The module SHALL have port out_valid  output  1  packet result valid.
REQ-013 The module SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 The module SHALL have port out_sum  output  WIDTH  packet sum, modulo 2^WIDTH.
REQ-015 The module SHALL have port out_count  output  CNT_W  number of beats in packet.
REQ-016 The module SHALL have port out_ovf  output  1  sticky: at least one wrap occurred in packet.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-018 add_a SHALL equal the internal accumulator register acc, and add_b SHALL equal in_data, both combinationally.
REQ-019 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-020 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-021 On each transfer, acc SHALL load add_c and the beat count SHALL increment.
REQ-022 The beat count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 On each transfer, if add_c < add_a (unsigned), the ovf flag SHALL be set, and it SHALL stay set until the packet is released.
REQ-024 On a transfer with in_last=0, the FSM SHALL go IDLE->ACC or stay in ACC.
REQ-025 On a transfer with in_last=1, the FSM SHALL go from IDLE or ACC to DONE.
REQ-026 A single-beat packet SHALL go IDLE->DONE with out_sum=in_data and out_count=1.
REQ-027 Without a transfer, the FSM SHALL hold its state, acc, count and ovf.
REQ-028 out_valid SHALL be 1 exactly while in DONE, asserting on the cycle after the last-beat transfer (latency 1 cycle).
REQ-029 In DONE, out_sum=acc, out_count=count and out_ovf=ovf, all held stable until the result handshake.
REQ-030 In DONE with out_ready=1, the FSM SHALL go to IDLE on that edge and clear acc, count and ovf to 0.
REQ-031 In DONE, in_valid SHALL be ignored; upstream holds its beat until in_ready returns.
REQ-032 A new beat SHALL be accepted no earlier than the cycle after the result handshake.
REQ-033 Outside DONE, out_sum, out_count and out_ovf SHALL read 0.
REQ-034 All arithmetic SHALL be performed by the external Adder; the block itself SHALL NOT add data words.

Reset
REQ-035 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE with acc=0, count=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0 and in_ready=1.
REQ-036 A reset asserted mid-packet or in DONE SHALL discard the partial or pending result with no output.
REQ-037 After rst_n deasserts, the first rising edge SHALL be able to accept a beat.

Verification
REQ-038 Reset scenario: pulse rst_n low between edges -> outputs zero immediately, in_ready=1, add_a=0.
REQ-039 Two-beat scenario: beats 10 then 20 (in_last on 20) -> out_valid next cycle, out_sum=30, out_count=2, out_ovf=0.
REQ-040 Single-beat scenario: beat 87 with in_last=1 -> out_sum=87, out_count=1.
REQ-041 Wrap scenario: beats 0xFFFFF then 2 (last) -> out_sum=1, out_ovf=1; the next packet 8,5 -> out_sum=13, out_ovf=0.
REQ-042 Backpressure scenario: out_ready=0 for 5 cycles after 15,2 -> out_valid=1, out_sum=17 stable, in_ready=0 throughout; out_ready=1 -> IDLE on the following edge.
REQ-043 Mid-packet reset scenario: beat 32 accepted, then rst_n pulsed low, then packet 22,17 -> out_sum=39 (not 71), out_count=2.
REQ-044 All scenarios SHALL run with this block connected to the Adder instance, and the bench SHALL check add_a and add_b on every transfer.
